// File: rtl/adc_sample_capture.sv
// ADC strobe synchronizer, rising-edge capture and show-ahead sample FIFO with overrun/count.
// Optional ADC_OFFSET_BINARY_EN: invert the captured MSB (offset-binary to two's complement).
module adc_sample_capture #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          adc_clock,
  input  logic [DATA_W-1:0]             adc_data,
  input  logic                          enable,
  input  logic                          clear_overrun,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [DATA_W-1:0]             sample_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  output logic [15:0]                   sample_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [DATA_W-1:0]      data_q;
  logic [DATA_W-1:0]      cap_word;
  logic [DATA_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [LVL_W-1:0]       level_nxt;
  logic                   adc_edge;
  logic                   push_req;
  logic                   pop;
  logic                   full;
  logic                   push;
  logic                   drop;

`ifdef ADC_OFFSET_BINARY_EN
  assign cap_word = {~adc_data[DATA_W-1], adc_data[DATA_W-2:0]};
`else
  assign cap_word = adc_data;
`endif

  assign adc_edge    = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign push_req    = adc_edge & enable;
  assign pop         = sample_valid & sample_ready;
  assign full        = (fifo_level == LVL_W'(FIFO_DEPTH));
  // At full a push only proceeds when the head leaves in the same cycle.
  assign push        = push_req & (~full | pop);
  assign drop        = push_req & full & ~pop;
  assign sample_data = mem[rd_ptr];

  always_comb begin
    level_nxt = fifo_level;
    unique case ({push, pop})
      2'b10:   level_nxt = fifo_level + LVL_W'(1);
      2'b01:   level_nxt = fifo_level - LVL_W'(1);
      default: level_nxt = fifo_level;
    endcase
  end

  // Sync/history flops reset high so an already-high strobe at release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '1;
      hist_q       <= 1'b1;
      data_q       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      sample_count <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], adc_clock};
      hist_q       <= sync_q[SYNC_STAGES-1];
      data_q       <= cap_word;
      fifo_level   <= level_nxt;
      sample_valid <= (level_nxt != '0);
      if (push) begin
        mem[wr_ptr]  <= data_q;
        wr_ptr       <= wr_ptr + PTR_W'(1);
        sample_count <= sample_count + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (drop) overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_sample_capture.sv
// Scoreboard bench for adc_sample_capture: directed strobe pulses, queue of expected words.
module tb_adc_sample_capture;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              adc_clock = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              enable = 1'b0;
  logic              clear_overrun = 1'b0;
  logic              sample_valid;
  logic              sample_ready = 1'b0;
  logic [DATA_W-1:0] sample_data;
  logic [2:0]        fifo_level;
  logic              overrun;
  logic [15:0]       sample_count;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] exp_q [$];

  adc_sample_capture #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .adc_clock(adc_clock), .adc_data(adc_data),
    .enable(enable), .clear_overrun(clear_overrun), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .sample_data(sample_data), .fifo_level(fifo_level),
    .overrun(overrun), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) check("unexpected_pop", 32'(sample_data), 32'hDEAD_BEEF);
      else check("pop_data", 32'(sample_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask

  // Strobe pulse: 8 cycles high, 8 low. The edge is visible in the cycle after the 2nd
  // clk rise following the strobe rise; rdy/clr are asserted for exactly that cycle.
  task automatic pulse(input logic [DATA_W-1:0] d, input bit rdy_at_edge, input bit clr_at_edge);
    logic old_rdy;
    old_rdy   = sample_ready;
    adc_data  = d;
    adc_clock = 1'b1;
    tick(2);
    if (rdy_at_edge) sample_ready = 1'b1;
    if (clr_at_edge) clear_overrun = 1'b1;
    tick(1);
    sample_ready  = old_rdy;
    clear_overrun = 1'b0;
    tick(5);
    adc_clock = 1'b0;
    tick(8);
  endtask

  initial begin
    int first;
    int vcnt;
    logic [DATA_W-1:0] ob_a;
    logic [DATA_W-1:0] ob_b;

    tick(3);
    check("reset_valid", 32'(sample_valid), 0);
    check("reset_level", 32'(fifo_level), 0);
    check("reset_overrun", 32'(overrun), 0);
    check("reset_count", 32'(sample_count), 0);
    check("reset_data", 32'(sample_data), 0);
    rst_n = 1'b1;
    tick(2);

    // Basic capture with continuous ready: valid for exactly one cycle.
    enable = 1'b1;
    sample_ready = 1'b1;
    exp_q.push_back(16'h1234);
    adc_data  = 16'h1234;
    adc_clock = 1'b1;
    first = 0;
    vcnt  = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (sample_valid) begin
        vcnt++;
        if (first == 0) first = k;
      end
    end
    @(posedge clk); #1;
    adc_clock = 1'b0;
    tick(8);
    check("basic_valid_cycles", 32'(vcnt), 1);
    check("basic_latency_in_range",
          32'((first >= int'(SYNC_STAGES) + 1) && (first <= int'(SYNC_STAGES) + 3)), 1);
    check("basic_count", 32'(sample_count), 1);

    // Fill and overrun: the fifth word is dropped.
    do_reset();
    enable = 1'b1;
    sample_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(16'(i));
      pulse(16'(i), 1'b0, 1'b0);
    end
    check("fill_level", 32'(fifo_level), 4);
    check("fill_overrun", 32'(overrun), 1);
    check("fill_count", 32'(sample_count), 4);

    clear_overrun = 1'b1;
    tick(1);
    clear_overrun = 1'b0;
    check("clear_overrun", 32'(overrun), 0);

    // Push and pop together at full.
    exp_q.push_back(16'h00AA);
    pulse(16'h00AA, 1'b1, 1'b0);
    check("pushpop_level", 32'(fifo_level), 4);
    check("pushpop_overrun", 32'(overrun), 0);
    check("pushpop_count", 32'(sample_count), 5);

    // Edges ignored while disabled.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) pulse(16'h0F0F, 1'b0, 1'b0);
    check("disabled_level", 32'(fifo_level), 4);
    check("disabled_count", 32'(sample_count), 5);
    check("disabled_overrun", 32'(overrun), 0);

    // Drop sets overrun; clear in the same cycle as another drop loses.
    enable = 1'b1;
    pulse(16'h00BB, 1'b0, 1'b0);
    check("drop_overrun", 32'(overrun), 1);
    pulse(16'h00CC, 1'b0, 1'b1);
    check("set_wins_overrun", 32'(overrun), 1);
    check("set_wins_count", 32'(sample_count), 5);

    // Drain: expects 2, 3, 4, AA.
    sample_ready = 1'b1;
    tick(8);
    check("drain_level", 32'(fifo_level), 0);
    check("drain_valid", 32'(sample_valid), 0);
    check("drain_queue_empty", 32'(exp_q.size()), 0);

    // Reset with two entries held and the strobe high.
    do_reset();
    enable = 1'b1;
    sample_ready = 1'b0;
    exp_q.push_back(16'h0011);
    pulse(16'h0011, 1'b0, 1'b0);
    exp_q.push_back(16'h0022);
    pulse(16'h0022, 1'b0, 1'b0);
    check("pre_reset_level", 32'(fifo_level), 2);
    enable = 1'b0;
    adc_data  = 16'h0099;
    adc_clock = 1'b1;
    tick(6);
    enable = 1'b1;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midreset_valid", 32'(sample_valid), 0);
    check("midreset_level", 32'(fifo_level), 0);
    check("midreset_data", 32'(sample_data), 0);
    check("midreset_count", 32'(sample_count), 0);
    check("midreset_overrun", 32'(overrun), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(8);
    check("release_no_edge_level", 32'(fifo_level), 0);
    check("release_no_edge_count", 32'(sample_count), 0);
    adc_clock = 1'b0;
    tick(8);
    sample_ready = 1'b1;
    exp_q.push_back(16'h0033);
    pulse(16'h0033, 1'b0, 1'b0);
    check("post_reset_count", 32'(sample_count), 1);

    // Offset-binary conversion (or pass-through in the default build).
`ifdef ADC_OFFSET_BINARY_EN
    ob_a = 16'h0000;
    ob_b = 16'h7FFF;
`else
    ob_a = 16'h8000;
    ob_b = 16'hFFFF;
`endif
    exp_q.push_back(ob_a);
    pulse(16'h8000, 1'b0, 1'b0);
    exp_q.push_back(ob_b);
    pulse(16'hFFFF, 1'b0, 1'b0);
    check("offset_count", 32'(sample_count), 3);
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_sample_capture.md
Name: adc_sample_capture

Overview:
- Front-end stage that sits directly upstream of the gain/multiplier stage.
- Brings the slow `adc_clock` strobe into the `clk` domain through a synchronizer and detects its rising edges.
- Captures the 16-bit ADC word on each detected edge and buffers it in a small FIFO.
- Presents samples to the multiplier over a valid/ready handshake, with overrun detection and a running sample count.

Parameters:
- DATA_W, 16, sample width in bits.
- FIFO_DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
- SYNC_STAGES, 2, number of synchronizer flops on `adc_clock`; must be at least 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- adc_clock  input  1  ADC sample strobe, asynchronous to `clk`.
- adc_data  input  DATA_W  ADC sample word; stable while `adc_clock` is high.
- enable  input  1  when 1, detected edges are captured.
- clear_overrun  input  1  synchronous clear of `overrun`.
- sample_valid  output  1  FIFO head is valid.
- sample_ready  input  1  downstream accepts the head.
- sample_data  output  DATA_W  FIFO head word.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- overrun  output  1  sticky flag: a sample was dropped because the FIFO was full.
- sample_count  output  16  number of accepted samples; wraps.

Behaviour:
- Reset values:
  - All outputs are 0.
  - FIFO pointers are 0.
  - Synchronizer and edge-history flops reset to 1, so an `adc_clock` that is already high at reset release gives no spurious edge.
- Edge detect:
  - `edge` = last sync stage is 1 AND edge-history flop is 0.
  - `edge` is a 1-cycle pulse.
  - It occurs SYNC_STAGES+1 `clk` cycles after the `adc_clock` rise (±1 cycle of metastability uncertainty).
- Capture:
  - `adc_data` is registered every cycle.
  - On `edge` AND `enable`, a push of the registered word is requested.
  - When `enable`=0, edges are ignored; the FIFO still drains.
- FIFO:
  - Show-ahead: `sample_data` = mem[rd_ptr].
  - `sample_valid` = (level != 0).
  - A pop occurs on `sample_valid` AND `sample_ready`.
  - The first push into an empty FIFO makes `sample_valid` rise on the next cycle.
  - `sample_data` is only defined while `sample_valid`=1; it is 0 after reset.
- Full:
  - A push with level = FIFO_DEPTH and no pop in the same cycle is dropped.
  - Memory and pointers are unchanged; `overrun` is set.
  - Push and pop in the same cycle at full are both performed; the level stays FIFO_DEPTH and there is no overrun.
- Empty:
  - `sample_ready` is ignored when `sample_valid`=0.
  - Push and pop in the same cycle at empty is impossible, since pop requires valid.
- Pointer wrap: pointers wrap modulo FIFO_DEPTH; the level is tracked separately.
- `sample_count`:
  - Increments by 1 per accepted push.
  - Wraps from 0xFFFF to 0x0000.
  - Dropped samples are not counted.
- `overrun`:
  - Set by a dropped push; cleared by `clear_overrun`.
  - Set wins if both occur in the same cycle.
- Reset mid-operation: FIFO contents are discarded immediately and all state returns to reset values; no partial pop is visible.
- Single-cycle throughput: `sample_ready` may be held high continuously; the FIFO then never holds more than 1 entry.

Optional Feature:
- Macro: ADC_OFFSET_BINARY_EN.
- Defined: the captured word has its MSB inverted before the FIFO, converting offset-binary ADC output to two's complement (0x8000 → 0x0000, 0x0000 → 0x8000, 0xFFFF → 0x7FFF).
- Not defined: words pass through unmodified.

Test Plan:
- Basic capture:
  - Stimulus: reset, `enable`=1, `sample_ready`=1; one `adc_clock` pulse (8 `clk` cycles high) with `adc_data`=0x1234.
  - Required: `sample_valid` is high for exactly 1 cycle with `sample_data`=0x1234, SYNC_STAGES+2 ±1 cycles after the rise; `sample_count`=1.
- Fill and overrun:
  - Stimulus: `sample_ready`=0; 5 pulses with data 0x0001..0x0005.
  - Required: `fifo_level`=4 and `overrun`=1; pops then return 0x0001..0x0004 in order; `sample_count`=4.
- Push/pop at full:
  - Stimulus: with the FIFO full, pulse `sample_ready` in the same cycle as `edge`, with data 0x00AA.
  - Required: `fifo_level` stays 4, `overrun` stays 0, and the last entry read out is 0x00AA.
- Enable and overrun clear:
  - Stimulus: `enable`=0 with 3 pulses; then assert `clear_overrun` in the same cycle as a dropped push.
  - Required: no pushes and `sample_count` unchanged; `overrun` remains 1.
- Reset behaviour:
  - Stimulus: assert `rst_n` low while `adc_clock`=1 and the FIFO holds 2 entries; release it.
  - Required: all outputs are 0, no `edge` on release, and the first capture happens only after `adc_clock` falls and rises again.
- Offset-binary option:
  - Stimulus: with ADC_OFFSET_BINARY_EN defined, `adc_data`=0x8000 then 0xFFFF.
  - Required: outputs are 0x0000 and 0x7FFF; without the macro, 0x8000 and 0xFFFF.
